al422_frame_writer: RTL and testbench

AL422_FRAME_WRITER -- requirements
Module: al422_frame_writer

---
 rtl/al422_frame_writer_pkg.sv | 29 ++
 rtl/al422_wr_phy.sv | 77 +++++++
 rtl/al422_frame_writer.sv | 155 +++++++++++++++
 tb/tb_al422_frame_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/al422_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : al422_frame_writer_pkg
// Description : Shared definitions for the AL422 frame writer. Holds the
//               writer FSM state encoding and the AL422 write-port pin
//               polarity constants used by the FSM and the pin sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package al422_frame_writer_pkg;

    // Writer FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRST  = 3'd1,
        ST_WR_LO = 3'd2,
        ST_WR_HI = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    // AL422 write-port pin levels
    localparam logic c_we_on    = 1'b0;   // /WE asserted
    localparam logic c_we_off   = 1'b1;
    localparam logic c_wrst_on  = 1'b0;   // /WRST asserted
    localparam logic c_wrst_off = 1'b1;
    localparam logic c_wck_lo   = 1'b0;
    localparam logic c_wck_hi   = 1'b1;

endpackage : al422_frame_writer_pkg
`default_nettype wire

// File: rtl/al422_wr_phy.sv
`default_nettype none
// ============================================================================
// Module      : al422_wr_phy
// Description : AL422 write-port pin sequencer. Registers WCK, /WE, /WRST and
//               write data from the writer FSM's next state, so every pin is
//               glitch-free and its level matches the FSM state it belongs to.
// Ports       : i_clk         system clock
//               i_rst_n       asynchronous active-low reset
//               i_state_nxt   FSM next state
//               i_wck_phase   WCK level to drive during the pointer reset
//               i_data        byte to present when entering the low WCK phase
//               o_wck/o_we_n/o_wrst_n/o_data  registered AL422 pins
// Revision    : 1.0 - initial release
// ============================================================================
module al422_wr_phy
    import al422_frame_writer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  state_t     i_state_nxt,
    input  logic       i_wck_phase,
    input  logic [7:0] i_data,
    output logic       o_wck,
    output logic       o_we_n,
    output logic       o_wrst_n,
    output logic [7:0] o_data
);

    logic       wck_q,    wck_d;
    logic       we_n_q,   we_n_d;
    logic       wrst_n_q, wrst_n_d;
    logic [7:0] data_q,   data_d;

    always_comb begin
        wck_d    = c_wck_lo;
        we_n_d   = c_we_off;
        wrst_n_d = c_wrst_off;
        data_d   = data_q;
        case (i_state_nxt)
            ST_WRST: begin
                wrst_n_d = c_wrst_on;
                wck_d    = i_wck_phase;
            end
            ST_WR_LO: begin
                // Data is set up while WCK is low, captured on the next rise
                we_n_d = c_we_on;
                data_d = i_data;
            end
            ST_WR_HI: begin
                we_n_d = c_we_on;
                wck_d  = c_wck_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wck_q    <= c_wck_lo;
            we_n_q   <= c_we_off;
            wrst_n_q <= c_wrst_off;
            data_q   <= 8'h00;
        end else begin
            wck_q    <= wck_d;
            we_n_q   <= we_n_d;
            wrst_n_q <= wrst_n_d;
            data_q   <= data_d;
        end
    end

    assign o_wck    = wck_q;
    assign o_we_n   = we_n_q;
    assign o_wrst_n = wrst_n_q;
    assign o_data   = data_q;

endmodule : al422_wr_phy
`default_nettype wire

// File: rtl/al422_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : al422_frame_writer
// Description : Streams byte frames into an AL422 FIFO. A start-of-frame
//               byte triggers a write-pointer reset, then each byte is
//               written with one low and one high WCK phase. A frame ends
//               after FRAME_BYTES bytes; an early start-of-frame aborts it.
// Ports       : in_clk, in_nrst           clock, async active-low reset
//               in_valid/in_data/in_sof   upstream byte stream
//               in_ready                  byte accepted when valid & ready
//               al422_wck/we_n/wrst_n/data  registered AL422 write port
//               frame_done, frame_err     one-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module al422_frame_writer
    import al422_frame_writer_pkg::*;
#(
    parameter int FRAME_BYTES = 256,
    parameter int WRST_CYCLES = 2
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    output logic       in_ready,
    output logic       al422_wck,
    output logic       al422_we_n,
    output logic       al422_wrst_n,
    output logic [7:0] al422_data,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int PH_W  = $clog2(2 * WRST_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FRAME_BYTES);
    localparam logic [PH_W-1:0]  c_ph_last  = PH_W'(2 * WRST_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PH_W-1:0]  ph_q,    ph_d;     // cycle index inside the pointer reset
    logic [7:0]       byte_q,  byte_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    logic             w_ready;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_accept  = in_valid & w_ready;
    // Saturating increment: the counter never wraps past a full frame
    assign w_cnt_inc = (cnt_q == c_cnt_full) ? cnt_q : cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                // Non-sof bytes are dropped here to resynchronise to a frame
                if (w_accept && in_sof) begin
                    byte_d  = in_data;
                    cnt_d   = '0;
                    ph_d    = '0;
                    state_d = ST_WRST;
                end
            end
            ST_WRST: begin
                if (ph_q == c_ph_last) begin
                    state_d = ST_WR_LO;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_WR_LO: begin
                state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                cnt_d   = w_cnt_inc;
                state_d = (w_cnt_inc == c_cnt_full) ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (w_accept) begin
                    byte_d = in_data;
                    if (in_sof) begin
                        // Early sof: restart with this byte as the new first
                        cnt_d   = '0;
                        ph_d    = '0;
                        state_d = ST_WRST;
                    end else begin
                        state_d = ST_WR_LO;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
        done_d  = (state_q == ST_WR_HI) && (w_cnt_inc == c_cnt_full);
        err_d   = (state_q == ST_WAIT) && w_accept && in_sof;
    end

    // Pins are registered from the next state so they line up with state_q
    al422_wr_phy u_phy (
        .i_clk       (in_clk),
        .i_rst_n     (in_nrst),
        .i_state_nxt (state_d),
        .i_wck_phase (ph_d[0]),
        .i_data      (byte_d),
        .o_wck       (al422_wck),
        .o_we_n      (al422_we_n),
        .o_wrst_n    (al422_wrst_n),
        .o_data      (al422_data)
    );

    assign in_ready   = w_ready;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule : al422_frame_writer
`default_nettype wire

// File: tb/tb_al422_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_al422_frame_writer
// Description : Directed self-checking bench for al422_frame_writer with
//               FRAME_BYTES=4 and WRST_CYCLES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_al422_frame_writer;
    import al422_frame_writer_pkg::*;

    localparam int FB = 4;
    localparam int WC = 2;

    logic       in_clk   = 1'b0;
    logic       in_nrst  = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_sof   = 1'b0;
    logic       in_ready;
    logic       al422_wck;
    logic       al422_we_n;
    logic       al422_wrst_n;
    logic [7:0] al422_data;
    logic       frame_done;
    logic       frame_err;

    al422_frame_writer #(
        .FRAME_BYTES (FB),
        .WRST_CYCLES (WC)
    ) dut (
        .in_clk       (in_clk),
        .in_nrst      (in_nrst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_ready     (in_ready),
        .al422_wck    (al422_wck),
        .al422_we_n   (al422_we_n),
        .al422_wrst_n (al422_wrst_n),
        .al422_data   (al422_data),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    always #5 in_clk = ~in_clk;

    int total = 0;
    int bad   = 0;

    // Pin monitor, sampled on the falling edge
    int         cyc = 0;
    logic       prev_wck = 1'b0;
    logic [7:0] wr_q[$];
    int         wr_cyc[$];
    int         wrst_lo = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         viol = 0;

    always @(negedge in_clk) begin
        cyc = cyc + 1;
        if (in_nrst) begin
            if (al422_wck && !prev_wck && !al422_we_n) begin
                wr_q.push_back(al422_data);
                wr_cyc.push_back(cyc);
            end
            if (!al422_wrst_n) wrst_lo = wrst_lo + 1;
            if (frame_done)    done_cnt = done_cnt + 1;
            if (frame_err)     err_cnt = err_cnt + 1;
            if (in_ready && (!al422_we_n || !al422_wrst_n)) viol = viol + 1;
        end
        prev_wck = al422_wck;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        #1;
        wr_q.delete();
        wr_cyc.delete();
        wrst_lo  = 0;
        done_cnt = 0;
        err_cnt  = 0;
        viol     = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_nrst  = 1'b0;
        repeat (2) @(negedge in_clk);
        in_nrst = 1'b1;
        clear_mon();
    endtask

    // Present a byte and return on the falling edge after it is accepted
    task automatic send_byte(input logic [7:0] d, input logic s, input bit keep);
        int n;
        n = 0;
        in_data  = d;
        in_sof   = s;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge in_clk);
            n = n + 1;
        end
        if (n >= 50) check($sformatf("send_ready_to_%0h", d), 32'(in_ready), 1);
        @(negedge in_clk);
        if (!keep) begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_wck"},    32'(al422_wck),    0);
        check({tag, "_we_n"},   32'(al422_we_n),   1);
        check({tag, "_wrst_n"}, 32'(al422_wrst_n), 1);
        check({tag, "_data"},   32'(al422_data),   0);
        check({tag, "_done"},   32'(frame_done),   0);
        check({tag, "_err"},    32'(frame_err),    0);
    endtask

    // Expected pins for the six cycles after the sof is accepted
    bit       e_wrst[6] = '{0, 0, 0, 0, 1, 1};
    bit       e_wck[6]  = '{0, 1, 0, 1, 0, 1};
    bit       e_we[6]   = '{1, 1, 1, 1, 0, 0};
    bit [7:0] f1[4]     = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        // ---------------- reset state ----------------
        @(negedge in_clk);
        check_reset_pins("rst");
        check("rst_ready", 32'(in_ready), 1);
        in_nrst = 1'b1;
        clear_mon();

        // ---------------- non-sof bytes in IDLE are dropped ----------------
        check("idle_ready", 32'(in_ready), 1);
        send_byte(8'h55, 1'b0, 1'b0);
        check("idle_we_n",   32'(al422_we_n),   1);
        check("idle_wrst_n", 32'(al422_wrst_n), 1);
        check("idle_wck",    32'(al422_wck),    0);
        check("idle_ready2", 32'(in_ready),     1);
        send_byte(8'h66, 1'b0, 1'b0);
        repeat (3) @(negedge in_clk);
        check("idle_writes", 32'(wr_q.size()), 0);
        check("idle_wrst",   32'(wrst_lo),     0);
        check("idle_pulses", 32'(done_cnt + err_cnt), 0);

        // ---------------- single frame with latency checks ----------------
        do_reset();
        send_byte(8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("lat%0d_wrst_n", i), 32'(al422_wrst_n), 32'(e_wrst[i]));
            check($sformatf("lat%0d_wck", i),    32'(al422_wck),    32'(e_wck[i]));
            check($sformatf("lat%0d_we_n", i),   32'(al422_we_n),   32'(e_we[i]));
            if (i >= 4) check($sformatf("lat%0d_data", i), 32'(al422_data), 32'h11);
            if (i < 5) @(negedge in_clk);
        end
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        // now in WR_LO of the last byte
        @(negedge in_clk);
        check("f1_done_hi_cycle", 32'(frame_done), 0);
        @(negedge in_clk);
        check("f1_done_pulse", 32'(frame_done), 1);
        @(negedge in_clk);
        check("f1_done_clear", 32'(frame_done), 0);
        check("f1_writes", 32'(wr_q.size()), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("f1_byte%0d", i), 32'(wr_q[i]), 32'(f1[i]));
        check("f1_done_cnt", 32'(done_cnt), 1);
        check("f1_err_cnt",  32'(err_cnt),  0);
        check("f1_wrst_lo",  32'(wrst_lo),  4);
        check("f1_state",    32'(dut.state_q), 32'(ST_IDLE));

        // ---------------- early sof aborts the frame ----------------
        do_reset();
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h77, 1'b1, 1'b0);
        repeat (12) @(negedge in_clk);
        check("ab_err_cnt",  32'(err_cnt),  1);
        check("ab_done_cnt", 32'(done_cnt), 0);
        check("ab_wrst_lo",  32'(wrst_lo),  8);
        check("ab_writes",   32'(wr_q.size()), 3);
        check("ab_byte2",    32'(wr_q[2]), 32'h77);

        // ---------------- continuous valid: one byte per 3 cycles ----------------
        do_reset();
        send_byte(8'hA0, 1'b1, 1'b1);
        check("cv_ready_wrst", 32'(in_ready), 0);
        send_byte(8'hA1, 1'b0, 1'b1);
        send_byte(8'hA2, 1'b0, 1'b1);
        send_byte(8'hA3, 1'b0, 1'b1);
        repeat (5) @(negedge in_clk);
        in_valid = 1'b0;
        check("cv_ready_viol", 32'(viol), 0);
        check("cv_writes",     32'(wr_q.size()), 4);
        for (int i = 0; i < 3; i++)
            check($sformatf("cv_gap%0d", i), 32'(wr_cyc[i+1] - wr_cyc[i]), 3);
        check("cv_byte3",    32'(wr_q[3]), 32'hA3);
        check("cv_done_cnt", 32'(done_cnt), 1);

        // ---------------- reset during WR_HI ----------------
        do_reset();
        send_byte(8'h11, 1'b1, 1'b0);
        repeat (5) @(negedge in_clk);
        check("mr_in_wr_hi", 32'(al422_wck), 1);
        #2 in_nrst = 1'b0;
        #1;
        check_reset_pins("mr");
        @(negedge in_clk);
        in_nrst = 1'b1;
        clear_mon();
        send_byte(8'h99, 1'b0, 1'b0);
        repeat (10) @(negedge in_clk);
        check("mr_writes", 32'(wr_q.size()), 0);
        check("mr_wrst",   32'(wrst_lo),     0);
        check("mr_pulses", 32'(done_cnt + err_cnt), 0);

        // ---------------- back-to-back frames ----------------
        do_reset();
        for (int i = 1; i <= 8; i++)
            send_byte(8'(i), (i == 1) || (i == 5), 1'b0);
        repeat (5) @(negedge in_clk);
        check("bb_done_cnt", 32'(done_cnt), 2);
        check("bb_err_cnt",  32'(err_cnt),  0);
        check("bb_wrst_lo",  32'(wrst_lo),  8);
        check("bb_writes",   32'(wr_q.size()), 8);
        check("bb_byte4",    32'(wr_q[4]), 32'h05);
        check("bb_byte7",    32'(wr_q[7]), 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule : tb_al422_frame_writer
`default_nettype wire
